// File: rtl/uart_tx_write_periph.sv
// ---------------------------------------------------------------------------
// uart_tx_write_periph
//
// Write-side memory-mapped UART transmitter for the single-cycle RISC-V MCU.
// CPU stores that land in the 0x2XXX peripheral window are decoded into a
// CTRL register and a DATA register.  A send command serialises the DATA
// byte onto tx_o as 8N1 (start bit, 8 data bits LSB first, stop bit).  Each
// bit lasts DIV = CLK_FREQ_HZ / BAUD_RATE clocks.
//
// Optional feature macro: UART_TX_IRQ_EN
//   defined   -> sticky tx-done flag in CTRL bit1 (write-1-to-clear) and an
//                irq_o output that mirrors it.
//   undefined -> irq_o port absent, CTRL bit1 reads 0, clear writes ignored.
//
// Ports
//   clk_i           in   1   core clock
//   rst_n_i         in   1   asynchronous reset, active low
//   we_i            in   1   CPU store strobe (one cycle per store)
//   Data_Address_o  in  32   store address from the ALU
//   wdata_i         in  32   store data
//   ctrl_rdata_o    out 32   CTRL read-back {30'b0, done, busy}
//   data_rdata_o    out 32   DATA read-back {24'b0, data_q}
//   tx_o            out  1   serial line, idles high, registered
//   irq_o           out  1   tx-done interrupt (UART_TX_IRQ_EN only)
// ---------------------------------------------------------------------------
module uart_tx_write_periph #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        we_i,
  input  logic [31:0] Data_Address_o,
  input  logic [31:0] wdata_i,
  output logic [31:0] ctrl_rdata_o,
  output logic [31:0] data_rdata_o,
  output logic        tx_o
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q;
  logic [7:0]      data_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_cnt_q;
  logic [CW-1:0]   baud_cnt_q;
  logic            busy_q;
  logic            tx_q;
  logic            done_q;

  logic            ctrl_hit;
  logic            data_hit;
  logic            start_ok;
  logic            baud_wrap;
  logic            stop_last;

  // CTRL takes priority over DATA so that the write map matches the read
  // map; e.g. 0x2018 satisfies both patterns and must land in CTRL.
  assign ctrl_hit  = we_i && (Data_Address_o[15:12] == 4'h2)
                          && (Data_Address_o[7:4]   == 4'h1);
  assign data_hit  = we_i && !ctrl_hit
                          && (Data_Address_o[15:12] == 4'h2)
                          && (Data_Address_o[3:0]   == 4'h8);
  assign start_ok  = ctrl_hit && wdata_i[0] && (state_q == IDLE);
  assign baud_wrap = (baud_cnt_q == DIV_LAST);
  assign stop_last = (state_q == STOP) && baud_wrap;

  // DATA holding register.  Writable at any time; the frame in flight is
  // unaffected because it transmits from its own shift_q snapshot.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= 8'h00;
    end else if (data_hit) begin
      data_q <= wdata_i[7:0];
    end
  end

  // Transmit FSM.  tx_q is loaded with the value of the state being
  // entered, so the line changes exactly on the state boundary and stays
  // glitch-free.  Every non-IDLE state lasts DIV clocks via baud_cnt_q.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      baud_cnt_q <= '0;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      if (state_q == IDLE) begin
        baud_cnt_q <= '0;
      end else if (baud_wrap) begin
        baud_cnt_q <= '0;
      end else begin
        baud_cnt_q <= baud_cnt_q + CW'(1);
      end

      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (start_ok) begin
            shift_q   <= data_q;
            busy_q    <= 1'b1;
            bit_cnt_q <= 3'd0;
            tx_q      <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            bit_cnt_q <= 3'd0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            if (bit_cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              tx_q      <= shift_q[bit_cnt_q + 3'd1];
            end
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (baud_wrap) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  // Sticky done flag.  A clear in the same cycle as the final stop clock
  // loses, so a completion can never be silently dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      done_q <= 1'b0;
    end else if (stop_last) begin
      done_q <= 1'b1;
    end else if (ctrl_hit && wdata_i[1]) begin
      done_q <= 1'b0;
    end
  end

  assign irq_o = done_q;
`else
  logic unused_done_inputs;
  assign unused_done_inputs = stop_last ^ wdata_i[1];
  assign done_q = 1'b0;
`endif

  // Address and data bits that the decode does not look at.
  logic unused_bits;
  assign unused_bits = ^{Data_Address_o[31:16], Data_Address_o[11:8],
                         wdata_i[31:8]};

  assign tx_o         = tx_q;
  assign ctrl_rdata_o = {30'b0, done_q, busy_q};
  assign data_rdata_o = {24'b0, data_q};

endmodule

// File: tb/tb_uart_tx_write_periph.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_write_periph
//
// Directed bench for uart_tx_write_periph at CLK_FREQ_HZ=100, BAUD_RATE=10,
// giving 10 clocks per bit.  Expected line levels are derived from the byte
// being sent (start, LSB-first data, stop).
// ---------------------------------------------------------------------------
module tb_uart_tx_write_periph;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] ctrlRdata;
  logic [31:0] dataRdata;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  int testsRun;
  int testsFailed;

  uart_tx_write_periph #(
    .CLK_FREQ_HZ (100),
    .BAUD_RATE   (10)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .we_i           (we),
    .Data_Address_o (addr),
    .wdata_i        (wdata),
    .ctrl_rdata_o   (ctrlRdata),
    .data_rdata_o   (dataRdata),
    .tx_o           (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq_o          (irq)
`endif
  );

  // 10 time-unit clock period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One CPU store: strobe for one cycle, return 1 ns after the capture edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
  endtask

  // Follow a full frame starting at its first low cycle.  With interfere set,
  // a DATA store of 0xFF and a second send are issued mid-frame.
  task automatic checkFrame(input logic [7:0] b, input bit interfere);
    logic expTx;
    for (int k = 0; k < 100; k++) begin
      if (k < 10)      expTx = 1'b0;
      else if (k < 90) expTx = b[(k - 10) / 10];
      else             expTx = 1'b1;
      checkOutput($sformatf("frame tx k=%0d", k), {31'b0, tx}, {31'b0, expTx});
      checkOutput($sformatf("frame busy k=%0d", k), {31'b0, ctrlRdata[0]}, 32'd1);
      if (interfere && k == 30) begin
        we = 1'b1; addr = 32'h0000_2008; wdata = 32'h0000_00FF;
      end else if (interfere && k == 50) begin
        we = 1'b1; addr = 32'h0000_2010; wdata = 32'h0000_0001;
      end else begin
        we = 1'b0; addr = 32'h0; wdata = 32'h0;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("frame end tx", {31'b0, tx}, 32'd1);
    checkOutput("frame end busy", {31'b0, ctrlRdata[0]}, 32'd0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;

    // Reset state, then 200 idle clocks with no stores
    #23;
    checkOutput("reset tx", {31'b0, tx}, 32'd1);
    checkOutput("reset ctrl", ctrlRdata, 32'h0);
    checkOutput("reset data", dataRdata, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      checkOutput("idle tx", {31'b0, tx}, 32'd1);
      checkOutput("idle ctrl", ctrlRdata, 32'h0);
      checkOutput("idle data", dataRdata, 32'h0);
    end

    // Basic 0x55 frame
    applyStimulus(32'h0000_2008, 32'h0000_0055);
    checkOutput("data 0x55", dataRdata, 32'h55);
    applyStimulus(32'h0000_2010, 32'h0000_0001);
    checkFrame(8'h55, 1'b0);

    // Mid-frame DATA store and send are absorbed without disturbing the frame
    applyStimulus(32'h0000_2010, 32'h0000_0001);
    checkFrame(8'h55, 1'b1);
    checkOutput("mid-frame data", dataRdata, 32'hFF);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      checkOutput("no 2nd frame tx", {31'b0, tx}, 32'd1);
      checkOutput("no 2nd frame busy", {31'b0, ctrlRdata[0]}, 32'd0);
    end

    // Stores outside the DATA slot are ignored
    applyStimulus(32'h0000_3008, 32'h0000_00A3);
    checkOutput("decode 0x3008", dataRdata, 32'hFF);
    applyStimulus(32'h0000_2004, 32'h0000_00A3);
    checkOutput("decode 0x2004", dataRdata, 32'hFF);
    applyStimulus(32'h0000_1008, 32'h0000_00A3);
    checkOutput("decode 0x1008", dataRdata, 32'hFF);
    // A CTRL store with bit0 clear does not start a frame
    applyStimulus(32'h0000_2010, 32'h0000_0000);
    checkOutput("ctrl bit0=0 busy", {31'b0, ctrlRdata[0]}, 32'd0);
    checkOutput("ctrl bit0=0 tx", {31'b0, tx}, 32'd1);
    // 0x2018 decodes as CTRL, not DATA
    applyStimulus(32'h0000_2018, 32'h0000_0001);
    checkOutput("0x2018 not data", dataRdata, 32'hFF);
    checkFrame(8'hFF, 1'b0);

    // Reset in the middle of a 0x5A frame
    applyStimulus(32'h0000_2008, 32'h0000_005A);
    applyStimulus(32'h0000_2010, 32'h0000_0001);
    repeat (35) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre-reset tx", {31'b0, tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset tx", {31'b0, tx}, 32'd1);
    checkOutput("mid reset ctrl", ctrlRdata, 32'h0);
    checkOutput("mid reset data", dataRdata, 32'h0);
    repeat (3) @(posedge clk);
    #4;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("post reset tx", {31'b0, tx}, 32'd1);
    applyStimulus(32'h0000_2008, 32'h0000_00C3);
    applyStimulus(32'h0000_2010, 32'h0000_0001);
    checkFrame(8'hC3, 1'b0);

`ifdef UART_TX_IRQ_EN
    // Done flag and interrupt
    checkOutput("irq set", {31'b0, irq}, 32'd1);
    checkOutput("ctrl done", ctrlRdata, 32'h2);
    applyStimulus(32'h0000_2010, 32'h0000_0002);
    checkOutput("irq cleared", {31'b0, irq}, 32'd0);
    checkOutput("ctrl cleared", ctrlRdata, 32'h0);
    applyStimulus(32'h0000_2010, 32'h0000_0001);
    checkFrame(8'hC3, 1'b0);
    checkOutput("irq set again", {31'b0, irq}, 32'd1);
    applyStimulus(32'h0000_2010, 32'h0000_0003);
    checkOutput("clear+send irq", {31'b0, irq}, 32'd0);
    checkOutput("clear+send ctrl", ctrlRdata, 32'h1);
    checkFrame(8'hC3, 1'b0);
    checkOutput("irq final", {31'b0, irq}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
